// File: rtl/z80_resp_pkg.sv
// Shared types and defaults for the Z80 bus responder: FSM states, port offsets and
// default parameter values.
package z80_resp_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StWait,
      StRead,
      StWrite,
      StInta,
      StDone
   } state_e;

   localparam logic [1:0] PortScratch0 = 2'd0;
   localparam logic [1:0] PortScratch1 = 2'd1;
   localparam logic [1:0] PortScratch2 = 2'd2;
   localparam logic [1:0] PortStatus   = 2'd3;

   localparam logic [7:0]  DefBasePage   = 8'h80;
   localparam logic [7:0]  DefIoBase     = 8'h10;
   localparam int unsigned DefWaitCycles = 2;
   localparam logic [7:0]  DefIntVector  = 8'hE0;

   function automatic logic [7:0] io_offset(input logic [7:0] addr, input logic [7:0] base);
      return addr - base;
   endfunction

endpackage

// File: rtl/z80_resp_ram.sv
// 256x8 RAM window for the Z80 bus responder: synchronous write, combinational read.
module z80_resp_ram (
   input  logic       i_clk,
   input  logic       i_we,
   input  logic [7:0] i_addr,
   input  logic [7:0] i_wdata,
   output logic [7:0] o_rdata
);

   logic [7:0] r_mem [256];

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/z80_bus_responder.sv
// Z80 bus slave: 256-byte RAM window, four I/O ports, interrupt request and INTA vector.
// Define Z80_RESP_WAIT_EN to insert WAIT_CYCLES wait states on RAM and I/O accesses.
module z80_bus_responder
   import z80_resp_pkg::*;
#(
   parameter logic [7:0]  BASE_PAGE   = DefBasePage,
   parameter logic [7:0]  IO_BASE     = DefIoBase,
   parameter int unsigned WAIT_CYCLES = DefWaitCycles,
   parameter logic [7:0]  INT_VECTOR  = DefIntVector
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] A,
   input  logic [7:0]  D_in,
   output logic [7:0]  D_out,
   output logic        D_oe,
   input  logic        nM1,
   input  logic        nMREQ,
   input  logic        nIORQ,
   input  logic        nRD,
   input  logic        nWR,
   input  logic        nRFSH,
   output logic        nWAIT,
   output logic        nINT,
   input  logic        irq_req
);

   localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES - 1);

   state_e      r_state;
   state_e      w_state_next;
   logic [15:0] r_a;
   logic [7:0]  r_d_in;
   logic        r_nm1, r_nmreq, r_niorq, r_nrd, r_nwr, r_nrfsh;
   logic        r_nmreq_p, r_niorq_p, r_nrd_p, r_nwr_p;
   logic        r_armed;
   logic [3:0]  r_wait_cnt;
   logic        r_is_io;
   logic [1:0]  r_port_idx;
   logic [7:0]  r_port [3];
   logic        r_pending;

   logic [7:0]  w_io_off;
   logic        w_mreq_fall, w_iorq_fall;
   logic        w_mem_sel, w_io_sel, w_inta_sel;
   logic        w_sel_high, w_strobe_rise;
   logic        w_wr_fire, w_status_clr, w_inta_clr;
   logic [7:0]  w_ram_rdata, w_rd_data;

   // Strobes reset to "low" so no edge is seen until both have been sampled high again.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_a       <= '0;
         r_d_in    <= '0;
         r_nm1     <= 1'b1;
         r_nmreq   <= 1'b0;
         r_niorq   <= 1'b0;
         r_nrd     <= 1'b1;
         r_nwr     <= 1'b1;
         r_nrfsh   <= 1'b1;
         r_nmreq_p <= 1'b0;
         r_niorq_p <= 1'b0;
         r_nrd_p   <= 1'b1;
         r_nwr_p   <= 1'b1;
         r_armed   <= 1'b0;
      end else begin
         r_a       <= A;
         r_d_in    <= D_in;
         r_nm1     <= nM1;
         r_nmreq   <= nMREQ;
         r_niorq   <= nIORQ;
         r_nrd     <= nRD;
         r_nwr     <= nWR;
         r_nrfsh   <= nRFSH;
         r_nmreq_p <= r_nmreq;
         r_niorq_p <= r_niorq;
         r_nrd_p   <= r_nrd;
         r_nwr_p   <= r_nwr;
         r_armed   <= r_armed | (r_nmreq & r_niorq);
      end
   end

   assign w_io_off      = io_offset(r_a[7:0], IO_BASE);
   assign w_mreq_fall   = r_armed & r_nmreq_p & ~r_nmreq & r_nrfsh;
   assign w_iorq_fall   = r_armed & r_niorq_p & ~r_niorq;
   assign w_mem_sel     = w_mreq_fall & (r_a[15:8] == BASE_PAGE);
   assign w_io_sel      = w_iorq_fall & r_nm1 & (w_io_off[7:2] == 6'd0);
   assign w_inta_sel    = w_iorq_fall & ~r_nm1;
   assign w_sel_high    = r_is_io ? r_niorq : r_nmreq;
   assign w_strobe_rise = (~r_nmreq_p & r_nmreq) | (~r_niorq_p & r_niorq) |
                          (~r_nrd_p & r_nrd) | (~r_nwr_p & r_nwr);
   assign w_wr_fire     = (r_state == StWrite) & ~r_nwr;
   assign w_status_clr  = w_wr_fire & r_is_io & (r_port_idx == PortStatus) & r_d_in[0];
   assign w_inta_clr    = (r_state == StInta) & r_niorq;

   z80_resp_ram u_ram (
      .i_clk   (clk),
      .i_we    (w_wr_fire & ~r_is_io),
      .i_addr  (r_a[7:0]),
      .i_wdata (r_d_in),
      .o_rdata (w_ram_rdata)
   );

   always_comb begin
      w_rd_data = w_ram_rdata;
      if (r_is_io) begin
         case (r_port_idx)
            PortScratch0: w_rd_data = r_port[0];
            PortScratch1: w_rd_data = r_port[1];
            PortScratch2: w_rd_data = r_port[2];
            default:      w_rd_data = {7'b0, r_pending};
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= StIdle;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         StIdle: begin
            if (w_inta_sel) begin
               w_state_next = StInta;
            end else if (w_mem_sel | w_io_sel) begin
`ifdef Z80_RESP_WAIT_EN
               w_state_next = StWait;
`else
               w_state_next = r_nrd ? StWrite : StRead;
`endif
            end
         end
         StWait: begin
            if (w_strobe_rise)           w_state_next = StDone;
            else if (r_wait_cnt == 4'd0) w_state_next = r_nrd ? StWrite : StRead;
         end
         StRead:  if (r_nrd | w_sel_high)     w_state_next = StDone;
         StWrite: if (~r_nwr | w_sel_high)    w_state_next = StDone;
         StInta:  if (r_niorq)                w_state_next = StDone;
         StDone:  if (r_nmreq & r_niorq)      w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   // D_oe is qualified by sampled nWR so the bus is never driven against a CPU write.
   always_comb begin
      D_oe  = 1'b0;
      D_out = 8'h00;
      nWAIT = 1'b1;
      case (r_state)
         StRead: begin
            D_oe  = ~r_nrd & r_nwr & ~w_sel_high;
            D_out = w_rd_data;
         end
         StInta: begin
            D_oe  = ~r_niorq & r_nwr;
            D_out = INT_VECTOR;
         end
`ifdef Z80_RESP_WAIT_EN
         StWait:  nWAIT = 1'b0;
`endif
         default: ;
      endcase
   end

   assign nINT = ~r_pending;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wait_cnt <= WaitLoad;
         r_is_io    <= 1'b0;
         r_port_idx <= 2'd0;
         for (int i = 0; i < 3; i++) r_port[i] <= 8'h00;
         r_pending  <= 1'b0;
      end else begin
         if (r_state == StIdle) begin
            r_wait_cnt <= WaitLoad;
         end else if (r_state == StWait && r_wait_cnt != 4'd0) begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
         end
         if (r_state == StIdle && (w_mem_sel | w_io_sel)) begin
            r_is_io    <= w_io_sel;
            r_port_idx <= w_io_off[1:0];
         end
         for (int i = 0; i < 3; i++) begin
            if (w_wr_fire && r_is_io && r_port_idx == 2'(i)) r_port[i] <= r_d_in;
         end
         // A new request wins over a same-cycle clear.
         r_pending <= irq_req | (r_pending & ~(w_status_clr | w_inta_clr));
      end
   end

endmodule

// File: doc/z80_bus_responder.md
Z80_BUS_RESPONDER -- requirements
Module: z80_bus_responder

Interface
REQ-001 Parameter BASE_PAGE, default 8'h80: A[15:8] value that selects the 256-byte RAM window.
REQ-002 Parameter IO_BASE, default 8'h10: A[7:0] of port 0; ports 0..3 occupy IO_BASE..IO_BASE+3.
REQ-003 Parameter WAIT_CYCLES, default 2: number of clk cycles nWAIT is held low per access (range 1..15).
REQ-004 Parameter INT_VECTOR, default 8'hE0: byte driven during interrupt acknowledge.
REQ-005 Ports, one per line:
 clk  in  1  bus clock, same as CPU CLK; all state on rising edge
 reset  in  1  asynchronous, active-high reset
 A  in  16  CPU address bus
 D_in  in  8  CPU data bus, sampled
 D_out  out  8  data driven to CPU
 D_oe  out  1  D_out enable, active-high
 nM1, nMREQ, nIORQ, nRD, nWR, nRFSH  in  1 each  CPU control strobes, active-low
 nWAIT  out  1  wait request to CPU, active-low
 nINT  out  1  interrupt request to CPU, active-low, level
 irq_req  in  1  local one-cycle interrupt pulse

Function
REQ-006 Strobes and A shall be registered once; all decoding shall use registered values; a cycle starts on a registered high-to-low edge of nMREQ (with nRFSH high) or of nIORQ.
REQ-007 Memory select: nMREQ low, nRFSH high, A[15:8]==BASE_PAGE; IO select: nIORQ low, nM1 high, A[7:0] in IO_BASE..IO_BASE+3; INTA select: nIORQ low and nM1 low.
REQ-008 Unselected cycles and refresh cycles (nRFSH low) shall leave the FSM in IDLE with D_oe=0 and nWAIT=1.
REQ-009 FSM states: IDLE, WAIT, READ, WRITE, INTA, DONE.
REQ-010 IDLE->WAIT on a memory/IO select; IDLE->INTA on INTA select; WAIT holds nWAIT=0 for exactly WAIT_CYCLES cycles, then enters READ if nRD low, else WRITE.
REQ-011 READ: D_out = RAM[A[7:0]] or port register, D_oe=1 until nRD or the selecting strobe is sampled high, then DONE.
REQ-012 WRITE: D_in shall be captured on the first cycle nWR is sampled low (one write per bus cycle), then DONE.
REQ-013 DONE: D_oe=0; return to IDLE once nMREQ and nIORQ are both sampled high.
REQ-014 INTA: D_out=INT_VECTOR, D_oe=1 while nIORQ is low; on nIORQ rise, clear the pending interrupt and go to DONE; no wait states in INTA.
REQ-015 Ports: 0..2 R/W scratch registers; port 3 read = {7'b0, pending}, write bit0=1 clears pending.
REQ-016 pending is set by irq_req; nINT = ~pending; a set and a clear in the same cycle leave pending=1.
REQ-017 Any strobe rising mid-WAIT shall abort to DONE with no write and nWAIT=1.
REQ-018 D_oe shall never be 1 while nWR is sampled low.

Reset
REQ-019 On reset assertion, immediately and asynchronously: FSM=IDLE, D_oe=0, D_out=8'h00, nWAIT=1, nINT=1, pending=0, ports 0..2=8'h00; RAM contents are undefined.
REQ-020 Reset mid-cycle shall abandon the cycle; after release the FSM waits for both strobes high before recognising a new edge.

Configuration
REQ-021 Macro Z80_RESP_WAIT_EN: defined -> WAIT state inserted per REQ-010; undefined -> WAIT skipped, nWAIT tied 1, READ/WRITE entered the cycle after select.

Structure
REQ-022 Shared package z80_resp_pkg: FSM state enum, port offset constants, default parameter values.
REQ-023 One sub-module z80_resp_ram: 256x8 synchronous-write, combinational-read RAM.

Verification
REQ-024 Memory write 8'h5A to 16'h8034, then read 16'h8034 -> nWAIT low 2 cycles each; read returns 8'h5A with D_oe=1.
REQ-025 Read of 16'h7F34 and a refresh cycle at 16'h8000 -> D_oe stays 0, nWAIT stays 1.
REQ-026 IO write 8'h01 to port 8'h13 after irq_req pulse -> nINT goes low then returns 1; port 3 reads 8'h00.
REQ-027 irq_req, then INTA (nM1+nIORQ low) -> D_out=8'hE0 with D_oe=1, nINT=1 after nIORQ rises.
REQ-028 Reset asserted during a READ with D_oe=1 -> D_oe=0 same cycle; next valid read completes normally.
REQ-029 Build without Z80_RESP_WAIT_EN -> nWAIT constant 1; REQ-024 data still correct.
